// File: rtl/pixel_delay_line.sv
// Multi-channel pixel delay line with a runtime-selectable latency of 1..MAX_DELAY clocks.
// A delay load flushes the valid pipeline so stale samples are never flagged valid.
module pixel_delay_line #(
  parameter int DATA_W    = 2,
  parameter int NUM_CH    = 2,
  parameter int MAX_DELAY = 4,
  localparam int DW       = $clog2(MAX_DELAY + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NUM_CH*DATA_W-1:0] din,
  input  logic                     din_valid,
  input  logic                     dly_load,
  input  logic [DW-1:0]            dly_sel,
  output logic [NUM_CH*DATA_W-1:0] dout,
  output logic                     dout_valid,
  output logic                     primed,
  output logic [DW-1:0]            cur_dly
);

  localparam int            W      = NUM_CH * DATA_W;
  localparam logic [DW-1:0] MAX_DW = DW'(MAX_DELAY);
  localparam logic [DW-1:0] ONE_DW = DW'(1);

  logic [W-1:0]         s_reg [1:MAX_DELAY];
  logic [W-1:0]         s_in  [1:MAX_DELAY];
  logic [MAX_DELAY:1]   v_reg;
  logic [MAX_DELAY:1]   v_in;
  logic [DW-1:0]        dly_reg;
  logic [DW-1:0]        fill_reg;
  logic [DW-1:0]        dly_next;
  logic [DW-1:0]        fill_next;

  genvar gi;
  generate
    for (gi = 1; gi <= MAX_DELAY; gi++) begin : g_stage_in
      if (gi == 1) begin : g_head
        assign s_in[gi] = din;
        assign v_in[gi] = din_valid;
      end else begin : g_tail
        assign s_in[gi] = s_reg[gi-1];
        assign v_in[gi] = v_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    dly_next = dly_sel;
    if (dly_sel == '0) begin
      dly_next = ONE_DW;
    end else if (dly_sel > MAX_DW) begin
      dly_next = MAX_DW;
    end
  end

  always_comb begin
    fill_next = fill_reg;
    if (fill_reg != MAX_DW) begin
      fill_next = fill_reg + ONE_DW;
    end
  end

  // Data stages only move with en; a load merely invalidates what is in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 1; k <= MAX_DELAY; k++) begin
        s_reg[k] <= '0;
      end
    end else if (en) begin
      for (int k = 1; k <= MAX_DELAY; k++) begin
        s_reg[k] <= s_in[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_reg    <= '0;
      fill_reg <= '0;
      dly_reg  <= ONE_DW;
    end else if (dly_load) begin
      v_reg    <= '0;
      v_reg[1] <= en & din_valid;
      fill_reg <= en ? ONE_DW : '0;
      dly_reg  <= dly_next;
    end else if (en) begin
      v_reg    <= v_in;
      fill_reg <= fill_next;
    end
  end

  assign dout       = s_reg[dly_reg];
  assign dout_valid = v_reg[dly_reg];
  assign primed     = (fill_reg >= dly_reg);
  assign cur_dly    = dly_reg;

endmodule

// File: tb/tb_pixel_delay_line.sv
// Scoreboard bench: two delay lines (2x2-bit and 3x8-bit) share control; each sample
// is queued with the enabled-edge index at which it must emerge.
module tb_pixel_delay_line;

  logic        clk = 1'b0;
  logic        rst_n, en, din_valid, dly_load;
  logic [2:0]  dly_sel;
  logic [3:0]  din_a, dout_a;
  logic [23:0] din_b, dout_b;
  logic        dout_valid_a, primed_a, dout_valid_b, primed_b;
  logic [2:0]  cur_dly_a, cur_dly_b;

  always #5 clk = ~clk;

  pixel_delay_line dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din_a), .din_valid(din_valid),
    .dly_load(dly_load), .dly_sel(dly_sel), .dout(dout_a), .dout_valid(dout_valid_a),
    .primed(primed_a), .cur_dly(cur_dly_a)
  );

  pixel_delay_line #(.DATA_W(8), .NUM_CH(3), .MAX_DELAY(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din_b), .din_valid(din_valid),
    .dly_load(dly_load), .dly_sel(dly_sel), .dout(dout_b), .dout_valid(dout_valid_b),
    .primed(primed_b), .cur_dly(cur_dly_b)
  );

  typedef struct {
    logic [3:0]  a;
    logic [23:0] b;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_dly  = 1;
  int          exp_fill = 0;
  int          cnt      = 0;
  logic        exp_v    = 1'b0;
  logic [3:0]  exp_a    = '0;
  logic [23:0] exp_b    = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int clampf(input logic [2:0] sel);
    if (sel == 3'd0) return 1;
    if (sel > 3'd4) return 4;
    return int'(sel);
  endfunction

  task automatic cycle(input logic e, input logic dv, input logic ld,
                       input logic [2:0] sel, input logic rn, input logic [3:0] da);
    logic [23:0] db;
    exp_t        item;
    db = 24'($urandom);
    rst_n = rn; en = e; din_valid = dv; dly_load = ld; dly_sel = sel;
    din_a = da; din_b = db;
    @(posedge clk);
    if (!rn) begin
      q.delete();
      exp_dly = 1; exp_fill = 0; cnt = 0;
    end else begin
      if (ld) begin
        q.delete();
        exp_dly  = clampf(sel);
        exp_fill = e ? 1 : 0;
      end else if (e && exp_fill < 4) begin
        exp_fill++;
      end
      if (e) begin
        cnt++;
        if (dv) begin
          item.a = da; item.b = db; item.due = cnt + exp_dly - 1;
          q.push_back(item);
        end
      end
    end
    if (!rn || e || ld) begin
      exp_v = 1'b0;
      if (q.size() > 0 && q[0].due == cnt) begin
        exp_v = 1'b1; exp_a = q[0].a; exp_b = q[0].b;
        q.delete(0);
      end
    end
    #1;
    $display("cyc rst_n=%0b en=%0b dv=%0b ld=%0b sel=%0d din=%h | dout=%h/%h v=%0b/%0b primed=%0b dly=%0d",
             rn, e, dv, ld, sel, da, dout_a, dout_b, dout_valid_a, dout_valid_b, primed_a, cur_dly_a);
    if (!rn) begin
      check("rst_dout_a", 32'(dout_a), 32'd0);
      check("rst_dout_b", 32'(dout_b), 32'd0);
    end
    check("valid_a", 32'(dout_valid_a), 32'(exp_v));
    check("valid_b", 32'(dout_valid_b), 32'(exp_v));
    check("primed_a", 32'(primed_a), 32'(exp_fill >= exp_dly));
    check("primed_b", 32'(primed_b), 32'(exp_fill >= exp_dly));
    check("cur_dly_a", 32'(cur_dly_a), 32'(exp_dly));
    check("cur_dly_b", 32'(cur_dly_b), 32'(exp_dly));
    if (exp_v) begin
      check("dout_a", 32'(dout_a), 32'(exp_a));
      check("dout_b", 32'(dout_b), 32'(exp_b));
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; din_valid = 1'b0; dly_load = 1'b0; dly_sel = '0;
    din_a = '0; din_b = '0;
    cycle(0, 0, 0, 0, 0, 4'h0);
    cycle(1, 1, 1, 3, 0, 4'hF);
    // Default delay of 1 after reset.
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 1, 4'(i + 1));
    // Delay 3 with an idle load edge.
    cycle(0, 0, 1, 3, 1, 4'h0);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 5, 1, 4'(4'hA + i));
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 1, 4'h0);
    // Delay 2 with a 5-cycle stall mid-stream.
    cycle(0, 0, 1, 2, 1, 4'h0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 1, 4'(i + 3));
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 6, 1, 4'hE);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 1, 4'(i + 7));
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1, 4'h0);
    // Clamp both ends, then a same-value reload while streaming.
    cycle(0, 0, 1, 0, 1, 4'h0);
    for (int i = 0; i < 2; i++) cycle(1, 1, 0, 0, 1, 4'(i + 5));
    cycle(0, 0, 1, 7, 1, 4'h0);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 1, 4'(i + 1));
    cycle(1, 1, 1, 4, 1, 4'hC);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 1, 4'(i + 8));
    // Load coincident with an enabled sample.
    cycle(1, 1, 1, 2, 1, 4'h9);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 1, 4'(i + 2));
    // Full delay-4 pipe interrupted by a one-cycle reset.
    cycle(0, 0, 1, 4, 1, 4'h0);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 1, 4'(i + 4));
    cycle(1, 1, 0, 0, 0, 4'hD);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 1, 4'(i + 1));
    // Random mix of enables, gaps, loads and occasional resets.
    for (int i = 0; i < 120; i++) begin
      cycle(($urandom % 4) != 0, $urandom % 2, ($urandom % 12) == 0,
            3'($urandom % 8), ($urandom % 40) != 0, 4'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pixel_delay_line.md
PIXEL_DELAY_LINE -- requirements
Module: pixel_delay_line

Interface
REQ-001 The block SHALL have parameter DATA_W, default 2, giving bits per channel.
REQ-002 The block SHALL have parameter NUM_CH, default 2, giving the number of parallel pixel channels.
REQ-003 The block SHALL have parameter MAX_DELAY, default 4 (legal range 1..64), giving the deepest selectable latency in clocks.
REQ-004 Local width DW SHALL equal $clog2(MAX_DELAY+1).
REQ-005 Port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-006 Port rst_n  input  1  reset, synchronous and active-low.
REQ-007 Port en  input  1  shift enable; 0 freezes the whole pipeline.
REQ-008 Port din  input  NUM_CH*DATA_W  channel c is bits [c*DATA_W +: DATA_W].
REQ-009 Port din_valid  input  1  qualifies din.
REQ-010 Port dly_load  input  1  one-cycle strobe that loads a new delay from dly_sel.
REQ-011 Port dly_sel  input  DW  requested latency in clocks.
REQ-012 Port dout  output  NUM_CH*DATA_W  delayed data, with the same channel packing as din.
REQ-013 Port dout_valid  output  1  qualifies dout.
REQ-014 Port primed  output  1  the pipeline holds at least dly_q enabled samples since the last reset or load.
REQ-015 Port cur_dly  output  DW  the active delay, dly_q.

Function
REQ-016 The block SHALL contain MAX_DELAY stages s[1..MAX_DELAY], each NUM_CH*DATA_W wide, plus one valid bit v[k] per stage.
REQ-017 On each clock edge with en=1, it SHALL update s[1]<=din, v[1]<=din_valid, and s[k]<=s[k-1], v[k]<=v[k-1] for k>=2.
REQ-018 On a clock edge with en=0, all s, v, and the fill counter SHALL hold their values.
REQ-019 dout SHALL equal s[dly_q] and dout_valid SHALL equal v[dly_q]; both are combinational from registers, with no extra register stage.
REQ-020 Latency SHALL therefore be exactly dly_q enabled clock edges, from din/din_valid to dout/dout_valid.
REQ-021 All channels SHALL be delayed identically, with no inter-channel skew.
REQ-022 On dly_load=1, dly_q SHALL load clamp(dly_sel): 0 maps to 1, values above MAX_DELAY map to MAX_DELAY, and all other values pass unchanged.
REQ-023 dly_load SHALL act independently of en.
REQ-024 On a dly_load edge, v[2..MAX_DELAY] SHALL clear to 0 and the fill counter SHALL clear.
REQ-025 The s[] data registers SHALL NOT be cleared on a dly_load edge.
REQ-026 If dly_load and en are both 1 on the same edge, v[1]<=din_valid and s[1]<=din SHALL still occur, and the fill counter SHALL become 1.
REQ-027 If dly_load=1 and en=0, v[1] SHALL also clear and the fill counter SHALL become 0.
REQ-028 The fill counter fill_q (width DW) SHALL increment on each en=1 edge and saturate at MAX_DELAY.
REQ-029 primed SHALL be 1 when fill_q >= dly_q.
REQ-030 dout_valid SHALL never assert after a load until the first post-load valid sample reaches s[dly_q], so no stale data is flagged valid.
REQ-031 A load that requests the same delay as dly_q SHALL still perform the full flush.
REQ-032 dly_sel SHALL be ignored when dly_load=0.

Reset
REQ-033 With rst_n=0 at a clock edge, the block SHALL clear all s[] to 0, all v[] to 0, and fill_q to 0, and set dly_q to 1.
REQ-034 Reset SHALL take priority over en and dly_load.
REQ-035 Values directly after reset SHALL be dout=0, dout_valid=0, primed=0, cur_dly=1.
REQ-036 Reset asserted mid-stream SHALL discard all in-flight samples; the first valid output after release SHALL be the first din sampled with en=1 after release.
REQ-037 At defaults (NUM_CH=2, DATA_W=2) after reset, the block SHALL behave as a 1-clock registered delay of both 2-bit channels.

Verification
REQ-038 Reset, then en=1 and din_valid=1 with din = 4'h1,2,3,4...: dout SHALL show 4'h1 one clock later, and dout_valid and primed SHALL be 1 from the first edge.
REQ-039 Load dly_sel=3, then stream 4'hA,B,C with en=1: dout_valid SHALL be 0 for 2 cycles and 4'hA SHALL appear exactly 3 edges after it was sampled; primed SHALL rise with fill_q=3.
REQ-040 Stall: with dly=2, drive en=0 for 5 cycles mid-stream: dout and dout_valid SHALL hold, and the sequence SHALL resume with no lost or duplicated sample.
REQ-041 Clamp: dly_sel=0 SHALL give cur_dly=1; dly_sel=7 with MAX_DELAY=4 SHALL give cur_dly=4; a same-value reload SHALL still drop dout_valid for dly_q-1 cycles.
REQ-042 Load coincident with en=1, dly_sel=2: the sample taken on that edge SHALL emerge valid 2 edges later, and no earlier sample SHALL be flagged valid.
REQ-043 Assert rst_n=0 for 1 cycle with dly=4 and a full pipe: all outputs SHALL be 0 and cur_dly=1 on the next cycle; repeat the test with NUM_CH=3, DATA_W=8 to check that channels stay aligned.
